// File: rtl/fixmul_pkg.sv
// fixmul_pkg: shared definitions for the sequential fixed-point multiplier.
//   - fixmul_state_e : controller states (IDLE, CALC, FINAL, DONE)
//   - default geometry localparams (K, ACC_W, rounding constant) for the
//     32-bit / Q24.8 / radix-1 configuration
//   - sat_limit()    : magnitude saturation limit for a given width and mode
package fixmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fixmul_state_e;

    // Widest operand the helper functions are sized for.
    localparam int MAX_W = 64;
    localparam int LIM_W = 2 * MAX_W + 1;

    localparam int DEF_C_WIDTH     = 32;
    localparam int DEF_FIXED_POINT = 8;
    localparam int DEF_RADIX_BITS  = 1;
    localparam int K               = DEF_C_WIDTH / DEF_RADIX_BITS;
    localparam int ACC_W           = 2 * DEF_C_WIDTH + DEF_RADIX_BITS;
    localparam logic [LIM_W-1:0] RND_CONST = LIM_W'(1) << (DEF_FIXED_POINT - 1);

    // Largest result magnitude representable for the mode:
    //   unsigned          : 2^w - 1
    //   signed, positive  : 2^(w-1) - 1
    //   signed, negative  : 2^(w-1)
    function automatic logic [LIM_W-1:0] sat_limit(input int w, input logic s_en,
                                                   input logic sgn);
        logic [LIM_W-1:0] one;
        one = LIM_W'(1);
        if (!s_en) begin
            return (one << w) - one;
        end else if (sgn) begin
            return one << (w - 1);
        end else begin
            return (one << (w - 1)) - one;
        end
    endfunction

endpackage

// File: rtl/fixmul_round_sat.sv
// fixmul_round_sat: combinational rounding, rescaling and saturation stage.
//   p        : 2*C_WIDTH-bit unsigned magnitude product
//   sign     : result is negative (only honoured when signed_en=1)
//   signed_en: two's-complement result
//   round_en : 1 = round half away from zero, 0 = truncate toward zero
//   y_next   : saturated, signed-corrected result
//   ovf_next : saturation occurred
module fixmul_round_sat
    import fixmul_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 8
) (
    input  logic [2*C_WIDTH-1:0] p,
    input  logic                 sign,
    input  logic                 signed_en,
    input  logic                 round_en,
    output logic [C_WIDTH-1:0]   y_next,
    output logic                 ovf_next
);

    // One extra bit so the rounding add can never wrap.
    localparam int PW = 2 * C_WIDTH + 1;
    localparam logic [PW-1:0] RND = PW'(1) << (FIXED_POINT - 1);

    logic            neg;
    logic [PW-1:0]   r_val;
    logic [PW-1:0]   q_val;
    logic [PW-1:0]   lim;
    logic [C_WIDTH-1:0] clamped;

    always_comb begin
        neg      = sign & signed_en;
        // Rounding is applied to the magnitude, which makes it symmetric
        // (half away from zero) once the sign is restored.
        r_val    = {1'b0, p} + (round_en ? RND : '0);
        q_val    = r_val >> FIXED_POINT;
        lim      = PW'(sat_limit(C_WIDTH, signed_en, neg));
        ovf_next = (q_val > lim);
        clamped  = ovf_next ? lim[C_WIDTH-1:0] : q_val[C_WIDTH-1:0];
        // Negating a zero magnitude yields zero, so there is no -0.
        y_next   = neg ? -clamped : clamped;
    end

endmodule

// File: rtl/fixmul_seq.sv
// fixmul_seq: sequential sign-magnitude fixed-point multiplier.
//   Consumes RADIX_BITS multiplier bits per CALC cycle (K = C_WIDTH/RADIX_BITS
//   cycles), then rounds/saturates in FINAL and holds the result in DONE.
//   Handshake: an operand set transfers on a rising edge with in_valid &
//   in_ready; a result transfers on a rising edge with out_valid & out_ready.
//   Neither side waits on the other combinationally, and a presented result
//   stays stable until it is taken.
// Ports:
//   ctl_clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready, a, b : operand handshake and operands
//   signed_en, round_en     : mode bits, sampled at acceptance only
//   out_valid/out_ready     : result handshake
//   y, ovf                  : result and saturation flag
//   busy                    : not IDLE
//   dbg_state               : current controller state
module fixmul_seq
    import fixmul_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 8,
    parameter int RADIX_BITS  = 1
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               signed_en,
    input  logic               round_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [C_WIDTH-1:0] y,
    output logic               ovf,
    output logic               busy,
    output fixmul_state_e      dbg_state
);

    localparam int KC    = C_WIDTH / RADIX_BITS;
    localparam int ACCW  = 2 * C_WIDTH + RADIX_BITS;
    localparam int PP_W  = C_WIDTH + RADIX_BITS;
    localparam int CNT_W = (KC > 1) ? $clog2(KC) : 1;
    localparam int LOG_R = $clog2(RADIX_BITS);

    if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4)) begin : g_bad_radix
        $error("fixmul_seq: RADIX_BITS must be 1, 2 or 4");
    end
    if (C_WIDTH % RADIX_BITS != 0) begin : g_bad_div
        $error("fixmul_seq: C_WIDTH must be a multiple of RADIX_BITS");
    end
    if (FIXED_POINT < 1 || FIXED_POINT > C_WIDTH - 1) begin : g_bad_fp
        $error("fixmul_seq: FIXED_POINT must be in 1..C_WIDTH-1");
    end
    if (C_WIDTH > MAX_W) begin : g_bad_w
        $error("fixmul_seq: C_WIDTH exceeds fixmul_pkg::MAX_W");
    end

    fixmul_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_WIDTH-1:0] a_mag_q, a_mag_d;
    logic [C_WIDTH-1:0] b_rem_q, b_rem_d;   // |b|, shifted down as slices are consumed
    logic               sign_q, sign_d;
    logic               sgn_en_q, sgn_en_d;
    logic               rnd_en_q, rnd_en_d;
    logic [ACCW-1:0]    acc_q, acc_d;
    logic [C_WIDTH-1:0] y_q, y_d;
    logic               ovf_q, ovf_d;

    logic [PP_W-1:0]    pp;
    logic [CNT_W+2:0]   shamt;
    logic [ACCW-1:0]    acc_add;
    logic [C_WIDTH-1:0] y_next;
    logic               ovf_next;
    logic               acc_unused;

    // The accumulator's top RADIX_BITS are headroom; the final magnitude
    // always fits in 2*C_WIDTH bits.
    assign acc_unused = ^acc_q[ACCW-1:2*C_WIDTH];

    fixmul_round_sat #(
        .C_WIDTH    (C_WIDTH),
        .FIXED_POINT(FIXED_POINT)
    ) u_round_sat (
        .p        (acc_q[2*C_WIDTH-1:0]),
        .sign     (sign_q),
        .signed_en(sgn_en_q),
        .round_en (rnd_en_q),
        .y_next   (y_next),
        .ovf_next (ovf_next)
    );

    always_comb begin
        pp      = PP_W'(a_mag_q) * PP_W'(b_rem_q[RADIX_BITS-1:0]);
        // Slice i lands at bit i*RADIX_BITS; RADIX_BITS is a power of two.
        shamt   = {3'b000, cnt_q} << LOG_R;
        acc_add = ACCW'(pp) << shamt;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_mag_d  = a_mag_q;
        b_rem_d  = b_rem_q;
        sign_d   = sign_q;
        sgn_en_d = sgn_en_q;
        rnd_en_d = rnd_en_q;
        acc_d    = acc_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_mag_d  = (signed_en && a[C_WIDTH-1]) ? -a : a;
                    b_rem_d  = (signed_en && b[C_WIDTH-1]) ? -b : b;
                    sign_d   = signed_en & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);
                    sgn_en_d = signed_en;
                    rnd_en_d = round_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_q + acc_add;
                b_rem_d = b_rem_q >> RADIX_BITS;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(KC - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                y_d     = y_next;
                ovf_d   = ovf_next;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_mag_q  <= '0;
            b_rem_q  <= '0;
            sign_q   <= 1'b0;
            sgn_en_q <= 1'b0;
            rnd_en_q <= 1'b0;
            acc_q    <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_mag_q  <= a_mag_d;
            b_rem_q  <= b_rem_d;
            sign_q   <= sign_d;
            sgn_en_q <= sgn_en_d;
            rnd_en_q <= rnd_en_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
